hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core. It pairs with the forwarding unit and covers hazards that forwarding cannot resolve.
- Generates PC and pipeline-register write enables and flush/bubble controls for:
  - load-use hazards
  - taken branches resolved in EX
  - a multicycle mult/div unit occupying EX
  - data-memory wait states
- Holds sequencing state and a stall performance counter.

---
 rtl/hazard_stall_controller.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencing for the 5-stage core: load-use, taken branch,
// multicycle mult/div occupancy of EX and data-memory wait states.
//   state     | meaning
//   RUN       | normal issue, hazard rules evaluated every cycle
//   MEM_WAIT  | whole pipeline frozen on a data-memory wait state
//   MULDIV    | front end held while a mult/div occupies EX
module hazard_stall_controller #(
   parameter int MULDIV_CYCLES = 8,
   parameter int COUNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [4:0]         if_id_rs,
   input  logic [4:0]         if_id_rt,
   input  logic               if_id_uses_rt,
   input  logic               id_ex_mem_read,
   input  logic [4:0]         id_ex_rt,
   input  logic               branch_taken,
   input  logic               muldiv_start,
   input  logic               mem_req,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               if_id_write,
   output logic               if_id_flush,
   output logic               id_ex_write,
   output logic               id_ex_flush,
   output logic               ex_mem_write,
   output logic               mem_wb_flush,
   output logic [1:0]         ctrl_state,
   output logic [COUNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_MULDIV   = 2'b10
   } state_t;

   localparam logic [7:0] LP_CNT_INIT = 8'(MULDIV_CYCLES - 2);

   state_t             r_state;
   state_t             w_next_state;
   logic [7:0]         r_cnt;
   logic [7:0]         w_next_cnt;
   logic [COUNT_W-1:0] r_stall_count;
   logic               w_load_use;
   logic               w_mem_stall;
   logic               w_freeze;
   logic               w_run_eval;
   logic               w_allow_muldiv;

   assign w_load_use  = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                        ((id_ex_rt == if_id_rs) ||
                         (if_id_uses_rt && (id_ex_rt == if_id_rt)));
   assign w_mem_stall = mem_req && !mem_ready;
   assign stall_count = r_stall_count;

   always_comb begin
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_write    = 1'b1;
      id_ex_flush    = 1'b0;
      ex_mem_write   = 1'b1;
      mem_wb_flush   = 1'b0;
      ctrl_state     = r_state;
      w_next_state   = r_state;
      w_next_cnt     = r_cnt;
      w_freeze       = 1'b0;
      w_run_eval     = 1'b0;
      w_allow_muldiv = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (w_mem_stall) begin
               w_freeze     = 1'b1;
               w_next_state = ST_MEM_WAIT;
            end else begin
               w_run_eval     = 1'b1;
               w_allow_muldiv = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_ready) begin
               w_freeze = 1'b1;
            end else begin
               w_run_eval     = 1'b1;
               w_allow_muldiv = 1'b1;
            end
         end
         ST_MULDIV: begin
            if (r_cnt != 8'd0) begin
               w_next_cnt = r_cnt - 8'd1;
               if (w_mem_stall) begin
                  w_freeze = 1'b1;
               end else begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_write = 1'b0;
               end
            end else if (w_mem_stall) begin
               w_freeze = 1'b1;
            end else begin
               w_run_eval = 1'b1;
            end
         end
         default: w_next_state = ST_RUN;
      endcase

      if (w_freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
      end

      // Release/exit cycles already behave as RUN, so they also report RUN.
      if (w_run_eval) begin
         ctrl_state   = ST_RUN;
         w_next_state = ST_RUN;
         if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (muldiv_start && w_allow_muldiv) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            w_next_cnt   = LP_CNT_INIT;
            w_next_state = ST_MULDIV;
         end else if (w_load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end

      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
         ctrl_state   = ST_RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_cnt         <= 8'd0;
         r_stall_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (!pc_write && (r_stall_count != {COUNT_W{1'b1}}))
            r_stall_count <= r_stall_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a table of single-cycle RUN
// decisions plus hand-written multi-cycle sequences.
module tb_hazard_stall_controller;

   localparam int CW = 4;

   localparam logic [6:0] DEF = 7'b1101010;
   localparam logic [6:0] LU  = 7'b0001110;
   localparam logic [6:0] BR  = 7'b1111110;
   localparam logic [6:0] MD  = 7'b0000010;
   localparam logic [6:0] FRZ = 7'b0000001;
   localparam logic [6:0] RST = 7'b0010101;

   logic          clk;
   logic          reset;
   logic [4:0]    if_id_rs;
   logic [4:0]    if_id_rt;
   logic          if_id_uses_rt;
   logic          id_ex_mem_read;
   logic [4:0]    id_ex_rt;
   logic          branch_taken;
   logic          muldiv_start;
   logic          mem_req;
   logic          mem_ready;
   logic          pc_write;
   logic          if_id_write;
   logic          if_id_flush;
   logic          id_ex_write;
   logic          id_ex_flush;
   logic          ex_mem_write;
   logic          mem_wb_flush;
   logic [1:0]    ctrl_state;
   logic [CW-1:0] stall_count;
   logic [6:0]    outs;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_stall_controller #(.MULDIV_CYCLES(8), .COUNT_W(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_id_rs       (if_id_rs),
      .if_id_rt       (if_id_rt),
      .if_id_uses_rt  (if_id_uses_rt),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rt       (id_ex_rt),
      .branch_taken   (branch_taken),
      .muldiv_start   (muldiv_start),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .id_ex_write    (id_ex_write),
      .id_ex_flush    (id_ex_flush),
      .ex_mem_write   (ex_mem_write),
      .mem_wb_flush   (mem_wb_flush),
      .ctrl_state     (ctrl_state),
      .stall_count    (stall_count)
   );

   assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_flush, ex_mem_write, mem_wb_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic       mrd;
      logic [4:0] ert;
      logic       br;
      logic       ms;
      logic       mq;
      logic       mr;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mrd, input logic [4:0] ert, input logic br,
                         input logic ms, input logic mq, input logic mr);
      if_id_rs       = rs;
      if_id_rt       = rt;
      if_id_uses_rt  = urt;
      id_ex_mem_read = mrd;
      id_ex_rt       = ert;
      branch_taken   = br;
      muldiv_start   = ms;
      mem_req        = mq;
      mem_ready      = mr;
   endtask

   task automatic zero_in();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      zero_in();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Inputs are already applied; sample mid-cycle, then advance one edge.
   task automatic cyc(input string name, input logic [6:0] exp_o, input logic [1:0] exp_s);
      #4;
      chk({name, ".outs"}, 32'(outs), 32'(exp_o));
      chk({name, ".state"}, 32'(ctrl_state), 32'(exp_s));
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, DEF};
      vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, LU};
      vecs[2]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, LU};
      vecs[3]  = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, DEF};
      vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, DEF};
      vecs[5]  = '{5'd5, 5'd5, 1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, DEF};
      vecs[6]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, BR};
      vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, MD};
      vecs[8]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, FRZ};
      vecs[9]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, LU};
      vecs[10] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, MD};
      vecs[11] = '{5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, LU};

      zero_in();
      reset = 1'b1;
      #1;
      chk("reset.outs", 32'(outs), 32'(RST));
      chk("reset.state", 32'(ctrl_state), 32'd0);
      chk("reset.count", 32'(stall_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_reset();
         set_in(vecs[i].rs, vecs[i].rt, vecs[i].urt, vecs[i].mrd, vecs[i].ert,
                vecs[i].br, vecs[i].ms, vecs[i].mq, vecs[i].mr);
         #4;
         chk($sformatf("vec%0d.outs", i), 32'(outs), 32'(vecs[i].exp));
         chk($sformatf("vec%0d.state", i), 32'(ctrl_state), 32'd0);
         @(posedge clk);
         #1;
         zero_in();
         chk($sformatf("vec%0d.count", i), 32'(stall_count), vecs[i].exp[6] ? 32'd0 : 32'd1);
      end

      // mult/div with muldiv_start held high: ignored inside MULDIV and on exit
      do_reset();
      for (int i = 0; i < 9; i++) begin
         zero_in();
         muldiv_start = (i <= 7);
         cyc($sformatf("muldiv%0d", i), (i < 7) ? MD : DEF,
             (i >= 1 && i <= 6) ? 2'b10 : 2'b00);
      end
      zero_in();
      chk("muldiv.count", 32'(stall_count), 32'd7);

      // memory wait, released together with a taken branch
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         cyc($sformatf("memwait%0d", i), FRZ, (i == 0) ? 2'b00 : 2'b01);
      end
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      cyc("memwait.release", BR, 2'b00);
      zero_in();
      cyc("memwait.after", DEF, 2'b00);
      chk("memwait.count", 32'(stall_count), 32'd3);

      // memory stalls inside MULDIV: mid-count and holding at counter zero
      do_reset();
      for (int i = 0; i < 10; i++) begin
         zero_in();
         muldiv_start = (i == 0);
         mem_req      = (i == 3) || (i >= 7);
         mem_ready    = (i == 9);
         cyc($sformatf("mdmem%0d", i),
             (i == 9) ? DEF : ((i == 3 || i == 7 || i == 8) ? FRZ : MD),
             (i >= 1 && i <= 8) ? 2'b10 : 2'b00);
      end
      zero_in();
      chk("mdmem.count", 32'(stall_count), 32'd9);

      // asynchronous reset between edges in the middle of MULDIV
      do_reset();
      muldiv_start = 1'b1;
      @(posedge clk);
      #1;
      zero_in();
      repeat (2) @(posedge clk);
      #1;
      chk("midrst.pre_count", 32'(stall_count), 32'd3);
      chk("midrst.pre_state", 32'(ctrl_state), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst.outs", 32'(outs), 32'(RST));
      chk("midrst.state", 32'(ctrl_state), 32'd0);
      chk("midrst.count", 32'(stall_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("midrst.resume0", DEF, 2'b00);
      cyc("midrst.resume1", DEF, 2'b00);
      chk("midrst.post_count", 32'(stall_count), 32'd0);

      // stall_count saturation with a 4-bit counter
      do_reset();
      mem_req = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      chk("sat.count14", 32'(stall_count), 32'd14);
      repeat (6) @(posedge clk);
      #1;
      chk("sat.count20", 32'(stall_count), 32'd15);
      zero_in();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
